// File: rtl/hilo_md_scheduler.sv
// Multiply/divide sequencer: hands MULT/DIV operands to the shared unit via a
// start/done handshake, owns HI/LO, and stalls decode while the unit is busy.
module hilo_md_scheduler #(
   parameter int unsigned MAX_CYCLES = 64,
   parameter int unsigned CNT_W      = 7
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush_e,
   input  logic        stall_e,
   input  logic        mult_en_e,
   input  logic        div_en_e,
   input  logic        unsigned_e,
   input  logic        hi_write_e,
   input  logic        lo_write_e,
   input  logic [31:0] src_a_e,
   input  logic [31:0] src_b_e,
   input  logic [31:0] wd_e,
   input  logic        hilo_use_d,
   output logic        md_start,
   output logic        md_is_div,
   output logic        md_unsigned,
   output logic [31:0] md_op_a,
   output logic [31:0] md_op_b,
   input  logic        md_done,
   input  logic [31:0] md_hi_in,
   input  logic [31:0] md_lo_in,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o,
   output logic        busy_o,
   output logic        stall_o,
   output logic        div0_err,
   output logic        timeout_err
);

   typedef enum logic [1:0] {IDLE, START, WAIT} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      hi_q, hi_d, lo_q, lo_d;
   logic [31:0]      op_a_q, op_a_d, op_b_q, op_b_d;
   logic             is_div_q, is_div_d, uns_q, uns_d;
   logic             div0_q, div0_d, tmo_q, tmo_d;
   logic             issue_e, md_issue, div_by_zero, move_issue;

   assign issue_e     = ~flush_e & ~stall_e;
   assign md_issue    = issue_e & (mult_en_e | div_en_e);
   assign div_by_zero = issue_e & div_en_e & (src_b_e == '0);
   assign move_issue  = issue_e & ~mult_en_e & ~div_en_e;

   // NOTE: every variable gets its hold value first, so no path through the
   // case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      op_a_d   = op_a_q;
      op_b_d   = op_b_q;
      is_div_d = is_div_q;
      uns_d    = uns_q;
      div0_d   = div0_q;
      tmo_d    = tmo_q;
      unique case (state_q)
         IDLE: begin
            if (div_by_zero) begin
               div0_d = 1'b1;
            end else if (md_issue) begin
               op_a_d   = src_a_e;
               op_b_d   = src_b_e;
               is_div_d = div_en_e;
               uns_d    = unsigned_e;
               state_d  = START;
            end
            if (move_issue & hi_write_e) hi_d = wd_e;
            if (move_issue & lo_write_e) lo_d = wd_e;
         end
         START: begin
            cnt_d   = CNT_W'(1);
            state_d = WAIT;
         end
         WAIT: begin
            if (md_done) begin
               hi_d    = md_hi_in;
               lo_d    = md_lo_in;
               state_d = IDLE;
            end else if (cnt_q == CNT_W'(MAX_CYCLES)) begin
               // Unit never answered: abandon the op and leave HI/LO alone.
               tmo_d   = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         op_a_q   <= '0;
         op_b_q   <= '0;
         is_div_q <= 1'b0;
         uns_q    <= 1'b0;
         div0_q   <= 1'b0;
         tmo_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         op_a_q   <= op_a_d;
         op_b_q   <= op_b_d;
         is_div_q <= is_div_d;
         uns_q    <= uns_d;
         div0_q   <= div0_d;
         tmo_q    <= tmo_d;
      end
   end

   assign md_start    = (state_q == START);
   assign md_is_div   = is_div_q;
   assign md_unsigned = uns_q;
   assign md_op_a     = op_a_q;
   assign md_op_b     = op_b_q;
   assign hi_o        = hi_q;
   assign lo_o        = lo_q;
   assign busy_o      = (state_q != IDLE);
   // The done cycle releases decode so a waiting MFHI/MFLO sees fresh HI/LO.
   assign stall_o     = busy_o & hilo_use_d & ~((state_q == WAIT) & md_done);
   assign div0_err    = div0_q;
   assign timeout_err = tmo_q;

`ifndef SYNTHESIS
   a_no_issue_while_busy: assert property (@(posedge clk) disable iff (!rst_n)
      busy_o |-> !(issue_e & (mult_en_e | div_en_e | hi_write_e | lo_write_e)));

   a_operands_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (state_q == WAIT) |-> $stable({op_a_q, op_b_q, is_div_q, uns_q}));
`endif

endmodule

// File: tb/tb_hilo_md_scheduler.sv
// Scoreboard bench for hilo_md_scheduler: directed scenarios plus randomized
// mult/div/move traffic, with a bench-side mult/div unit model.
module tb_hilo_md_scheduler;

   localparam int MAX_CYCLES = 64;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush_e, stall_e, mult_en_e, div_en_e, unsigned_e;
   logic        hi_write_e, lo_write_e, hilo_use_d;
   logic [31:0] src_a_e, src_b_e, wd_e;
   logic        md_start, md_is_div, md_unsigned, md_done;
   logic [31:0] md_op_a, md_op_b, md_hi_in, md_lo_in, hi_o, lo_o;
   logic        busy_o, stall_o, div0_err, timeout_err;

   hilo_md_scheduler #(.MAX_CYCLES(MAX_CYCLES), .CNT_W(7)) dut (
      .clk(clk), .rst_n(rst_n), .flush_e(flush_e), .stall_e(stall_e),
      .mult_en_e(mult_en_e), .div_en_e(div_en_e), .unsigned_e(unsigned_e),
      .hi_write_e(hi_write_e), .lo_write_e(lo_write_e),
      .src_a_e(src_a_e), .src_b_e(src_b_e), .wd_e(wd_e), .hilo_use_d(hilo_use_d),
      .md_start(md_start), .md_is_div(md_is_div), .md_unsigned(md_unsigned),
      .md_op_a(md_op_a), .md_op_b(md_op_b), .md_done(md_done),
      .md_hi_in(md_hi_in), .md_lo_in(md_lo_in), .hi_o(hi_o), .lo_o(lo_o),
      .busy_o(busy_o), .stall_o(stall_o), .div0_err(div0_err), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference arithmetic: returns {hi, lo} for one mult/div operation.
   function automatic logic [63:0] ref_md(input logic is_div, input logic uns,
                                          input logic [31:0] a, input logic [31:0] b);
      longint sa, sb;
      logic [63:0] p;
      logic [31:0] q, r;
      sa = $signed(a);
      sb = $signed(b);
      if (!is_div) begin
         if (uns) p = {32'h0, a} * {32'h0, b};
         else     p = 64'(sa * sb);
         return p;
      end
      if (uns) begin
         q = a / b;
         r = a % b;
      end else begin
         q = 32'(sa / sb);
         r = 32'(sa % sb);
      end
      return {r, q};
   endfunction

   typedef struct packed {
      logic        is_div;
      logic        uns;
      logic [31:0] a;
      logic [31:0] b;
   } start_t;

   start_t      start_q[$];
   logic [63:0] res_q[$];

   // Bench-side mult/div unit: answers unit_lat cycles after seeing md_start.
   int unit_lat  = 4;
   bit unit_dead = 1'b0;
   logic [63:0] unit_res;

   initial begin
      md_done  = 1'b0;
      md_hi_in = $urandom;
      md_lo_in = $urandom;
      forever begin
         @(negedge clk);
         if (md_start && !unit_dead) begin
            unit_res = ref_md(md_is_div, md_unsigned, md_op_a, md_op_b);
            repeat (unit_lat) @(posedge clk);
            #1;
            md_done = 1'b1;
            {md_hi_in, md_lo_in} = unit_res;
            @(posedge clk);
            #1;
            md_done  = 1'b0;
            md_hi_in = $urandom;
            md_lo_in = $urandom;
         end
      end
   end

   // Monitor: pops expected starts and HI/LO commits as the DUT presents them.
   bit     commit_pending = 1'b0;
   start_t mon_s;
   logic [63:0] mon_e;

   initial begin
      forever begin
         @(negedge clk);
         if (commit_pending) begin
            commit_pending = 1'b0;
            if (res_q.size() == 0) begin
               check("unexpected commit, queue depth", 64'(res_q.size()), 64'd1);
            end else begin
               mon_e = res_q.pop_front();
               check("commit hi", hi_o, mon_e[63:32]);
               check("commit lo", lo_o, mon_e[31:0]);
            end
         end
         if (md_start) begin
            if (start_q.size() == 0) begin
               check("unexpected md_start, queue depth", 64'(start_q.size()), 64'd1);
            end else begin
               mon_s = start_q.pop_front();
               check("start op_a", md_op_a, mon_s.a);
               check("start op_b", md_op_b, mon_s.b);
               check("start is_div/unsigned", {md_is_div, md_unsigned}, {mon_s.is_div, mon_s.uns});
            end
         end
         if (md_done && busy_o) commit_pending = 1'b1;
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Called at posedge+1; returns at posedge+1 of the cycle after the issue edge.
   task automatic issue_md(input logic is_div, input logic uns, input logic [31:0] a,
                           input logic [31:0] b, input bit expect_res, input bit squash);
      start_t s;
      mult_en_e  = ~is_div;
      div_en_e   = is_div;
      unsigned_e = uns;
      src_a_e    = a;
      src_b_e    = b;
      if (squash) begin
         if ($urandom_range(0, 1) == 0) flush_e = 1'b1;
         else                           stall_e = 1'b1;
      end else if (!(is_div && b == 32'h0)) begin
         s.is_div = is_div;
         s.uns    = uns;
         s.a      = a;
         s.b      = b;
         start_q.push_back(s);
         if (expect_res) res_q.push_back(ref_md(is_div, uns, a, b));
      end
      step(1);
      mult_en_e  = 1'b0;
      div_en_e   = 1'b0;
      unsigned_e = 1'b0;
      flush_e    = 1'b0;
      stall_e    = 1'b0;
      src_a_e    = $urandom;
      src_b_e    = $urandom;
   endtask

   task automatic move(input bit to_hi, input logic [31:0] d, input bit squash);
      hi_write_e = to_hi;
      lo_write_e = ~to_hi;
      wd_e       = d;
      flush_e    = squash;
      step(1);
      hi_write_e = 1'b0;
      lo_write_e = 1'b0;
      flush_e    = 1'b0;
      wd_e       = $urandom;
   endtask

   // Counts busy cycles (sampled at negedge) and checks stall and operand hold.
   task automatic watch(input string tag, input int limit, output int busy_cnt);
      bit          stall_ok, held_ok, first;
      logic [65:0] held;
      stall_ok = 1'b1;
      held_ok  = 1'b1;
      first    = 1'b1;
      held     = '0;
      busy_cnt = 0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (!busy_o) break;
         busy_cnt++;
         if (stall_o !== (hilo_use_d & ~md_done)) stall_ok = 1'b0;
         if (first) begin
            held  = {md_is_div, md_unsigned, md_op_a, md_op_b};
            first = 1'b0;
         end else if (held !== {md_is_div, md_unsigned, md_op_a, md_op_b}) begin
            held_ok = 1'b0;
         end
      end
      check({tag, " stall_o while busy"}, 64'(stall_ok), 64'd1);
      check({tag, " operands held"}, 64'(held_ok), 64'd1);
   endtask

   initial begin
      #500_000;
      $display("FAIL global time limit reached");
      $fatal(1, "simulation time limit");
   end

   int          bc, kind;
   bit          found, stall_ok, no_start, sq, is_div, uns;
   logic [31:0] a, b, d, exp_hi, exp_lo;

   initial begin
      rst_n = 1'b0;
      {flush_e, stall_e, mult_en_e, div_en_e, unsigned_e, hi_write_e, lo_write_e} = '0;
      src_a_e = '0; src_b_e = '0; wd_e = '0;
      hilo_use_d = 1'b1;
      step(3);
      check("reset hi/lo", {hi_o, lo_o}, 64'h0);
      check("reset operands", {md_op_a, md_op_b}, 64'h0);
      check("reset flags", {busy_o, stall_o, md_start, md_is_div, md_unsigned, div0_err, timeout_err}, 64'h0);
      rst_n = 1'b1;
      hilo_use_d = 1'b0;
      step(1);

      // Moves while idle, then squashed moves.
      move(1'b1, 32'hDEADBEEF, 1'b0);
      check("mthi hi", hi_o, 32'hDEADBEEF);
      check("mthi lo untouched", lo_o, 32'h0);
      move(1'b0, 32'h12345678, 1'b0);
      check("mtlo lo", lo_o, 32'h12345678);
      check("mtlo hi untouched", hi_o, 32'hDEADBEEF);
      move(1'b1, 32'hCAFEF00D, 1'b1);
      check("flushed mthi", hi_o, 32'hDEADBEEF);
      stall_e = 1'b1;
      move(1'b0, 32'h0BADF00D, 1'b0);
      stall_e = 1'b0;
      check("stalled mtlo", lo_o, 32'h12345678);

      // MULT -3 * 5, unit latency 4, MFLO waiting in decode.
      unit_lat   = 4;
      hilo_use_d = 1'b1;
      issue_md(1'b0, 1'b0, 32'hFFFFFFFD, 32'd5, 1'b1, 1'b0);
      watch("mult", 20, bc);
      check("mult busy cycles", 64'(bc), 64'd5);
      check("mult result", {hi_o, lo_o}, 64'hFFFFFFFF_FFFFFFF1);
      check("mult stall released", stall_o, 1'b0);
      step(1);

      // DIVU 100 / 7, unit latency 32.
      unit_lat = 32;
      issue_md(1'b1, 1'b1, 32'd100, 32'd7, 1'b1, 1'b0);
      watch("divu", 60, bc);
      check("divu busy cycles", 64'(bc), 64'd33);
      check("divu result", {hi_o, lo_o}, {32'd2, 32'd14});
      check("divu md_unsigned after op", md_unsigned, 1'b1);
      step(1);

      // DIV by zero: no start, sticky flag, HI/LO untouched.
      move(1'b1, 32'h11, 1'b0);
      move(1'b0, 32'h22, 1'b0);
      issue_md(1'b1, 1'b0, 32'd1234, 32'd0, 1'b1, 1'b0);
      check("div0 flag", div0_err, 1'b1);
      check("div0 busy", busy_o, 1'b0);
      step(5);
      check("div0 hi/lo unchanged", {hi_o, lo_o}, {32'h11, 32'h22});
      check("div0 still idle", busy_o, 1'b0);

      // Unit never answers: watchdog after MAX_CYCLES WAIT cycles.
      unit_dead = 1'b1;
      issue_md(1'b0, 1'b1, 32'd7, 32'd9, 1'b0, 1'b0);
      watch("timeout", 100, bc);
      check("timeout busy cycles", 64'(bc), 64'(MAX_CYCLES + 1));
      check("timeout flag", timeout_err, 1'b1);
      check("timeout stall released", stall_o, 1'b0);
      check("timeout hi/lo unchanged", {hi_o, lo_o}, {32'h11, 32'h22});
      step(1);

      // Reset in the middle of WAIT.
      issue_md(1'b1, 1'b0, 32'd50, 32'd3, 1'b0, 1'b0);
      step(10);
      check("pre-reset busy", busy_o, 1'b1);
      rst_n = 1'b0;
      #1;
      check("async reset hi/lo", {hi_o, lo_o}, 64'h0);
      check("async reset operands", {md_op_a, md_op_b}, 64'h0);
      check("async reset flags", {busy_o, stall_o, md_start, md_is_div, md_unsigned, div0_err, timeout_err}, 64'h0);
      step(2);
      rst_n    = 1'b1;
      no_start = 1'b1;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (md_start !== 1'b0) no_start = 1'b0;
      end
      check("no start after reset", 64'(no_start), 64'd1);
      unit_dead = 1'b0;
      step(1);

      // Back-to-back MULT then DIV held in decode until the done cycle.
      unit_lat   = 3;
      hilo_use_d = 1'b1;
      issue_md(1'b0, 1'b0, 32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b0);
      stall_ok = 1'b1;
      found    = 1'b0;
      for (int i = 0; i < 50 && !found; i++) begin
         @(negedge clk);
         if (md_done && busy_o) begin
            found = 1'b1;
            check("b2b stall released on done", stall_o, 1'b0);
         end else if (stall_o !== 1'b1) begin
            stall_ok = 1'b0;
         end
      end
      check("b2b done seen", 64'(found), 64'd1);
      check("b2b stall held", 64'(stall_ok), 64'd1);
      unit_lat = 5;
      step(1);
      issue_md(1'b1, 1'b0, 32'hFFFFFF9C, 32'd7, 1'b1, 1'b0);
      @(negedge clk);
      check("b2b second start timing", md_start, 1'b1);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!busy_o) break;
      end
      check("b2b div result", {hi_o, lo_o}, ref_md(1'b1, 1'b0, 32'hFFFFFF9C, 32'd7));
      {exp_hi, exp_lo} = ref_md(1'b1, 1'b0, 32'hFFFFFF9C, 32'd7);
      step(1);

      // Randomized traffic: ops and moves, some squashed.
      for (int i = 0; i < 40; i++) begin
         kind       = int'($urandom_range(0, 9));
         hilo_use_d = 1'($urandom_range(0, 1));
         sq         = ($urandom_range(0, 7) == 0);
         if (kind < 6) begin
            is_div = 1'($urandom_range(0, 1));
            uns    = 1'($urandom_range(0, 1));
            a      = $urandom;
            b      = (kind == 0) ? 32'($urandom_range(1, 7)) : $urandom;
            if (b == 32'h0) b = 32'd1;
            unit_lat = int'($urandom_range(1, 10));
            issue_md(is_div, uns, a, b, 1'b1, sq);
            if (sq) begin
               check("rand squashed op idle", busy_o, 1'b0);
            end else begin
               watch("rand op", 40, bc);
               check("rand busy cycles", 64'(bc), 64'(unit_lat + 1));
               {exp_hi, exp_lo} = ref_md(is_div, uns, a, b);
               step(1);
            end
         end else begin
            d = $urandom;
            move(kind[0], d, sq);
            if (!sq) begin
               if (kind[0]) exp_hi = d;
               else         exp_lo = d;
            end
            check("rand move hi/lo", {hi_o, lo_o}, {exp_hi, exp_lo});
         end
         step(int'($urandom_range(0, 2)));
      end

      step(5);
      check("start queue drained", 64'(start_q.size()), 64'd0);
      check("result queue drained", 64'(res_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/hilo_md_scheduler.md
Name: hilo_md_scheduler

Overview:
- Sequences the shared multi-cycle multiply/divide resource and owns the architectural HI/LO registers.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the EX stage and starts the external mult/div unit via a start/done handshake.
- Captures results into HI/LO.
- Stalls decode while a HI/LO consumer or a second mult/div/move waits on a busy unit.

Parameters:
MAX_CYCLES, 64, watchdog limit on busy cycles before the operation is aborted
CNT_W, 7, busy-counter width; must satisfy 2^CNT_W > MAX_CYCLES

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  reset, asynchronous, active-low
flush_e  in  1  EX-stage instruction is squashed; ignore all *_e issue inputs
stall_e  in  1  EX stage frozen; ignore all *_e issue inputs
mult_en_e  in  1  MULT/MULTU in EX
div_en_e  in  1  DIV/DIVU in EX
unsigned_e  in  1  unsigned variant of the EX op
hi_write_e  in  1  MTHI in EX (only meaningful when mult_en_e=div_en_e=0)
lo_write_e  in  1  MTLO in EX (only meaningful when mult_en_e=div_en_e=0)
src_a_e  in  32  rs operand
src_b_e  in  32  rt operand
wd_e  in  32  MTHI/MTLO write data
hilo_use_d  in  1  instruction in decode is MFHI/MFLO/MTHI/MTLO/MULT*/DIV*
md_start  out  1  one-cycle start pulse to the mult/div unit
md_is_div  out  1  1 = divide, 0 = multiply; held during the operation
md_unsigned  out  1  held during the operation
md_op_a  out  32  held during the operation
md_op_b  out  32  held during the operation
md_done  in  1  unit result valid, one-cycle pulse
md_hi_in  in  32  unit HI result (product high word or remainder)
md_lo_in  in  32  unit LO result (product low word or quotient)
hi_o  out  32  HI register
lo_o  out  32  LO register
busy_o  out  1  operation outstanding
stall_o  out  1  stall fetch/decode
div0_err  out  1  sticky: a divide by zero was issued
timeout_err  out  1  sticky: the watchdog fired

Behaviour:
- Valid issue: issue_e = ~flush_e & ~stall_e.
- Reset (async, rst_n=0): state IDLE; all outputs listed above are 0, including md_op_a/md_op_b and the busy counter.
- FSM states are IDLE, START and WAIT.
- IDLE:
  - issue_e & div_en_e & src_b_e==0: no start is issued; div0_err <= 1; HI/LO unchanged; remain IDLE.
  - issue_e & (mult_en_e | div_en_e), otherwise: latch operands, md_is_div and md_unsigned; go to START.
  - issue_e & hi_write_e: hi_o <= wd_e at the next edge. issue_e & lo_write_e: lo_o <= wd_e at the next edge.
- START: md_start=1 for exactly this cycle; counter <= 1; go to WAIT. md_done sampled in START is ignored.
- WAIT:
  - md_done=1: hi_o <= md_hi_in and lo_o <= md_lo_in at that edge; go to IDLE.
  - md_done=0 and counter==MAX_CYCLES: go to IDLE; timeout_err <= 1; HI/LO unchanged.
  - Otherwise counter increments.
- busy_o = (state != IDLE).
- stall_o (combinational) = busy_o & hilo_use_d & ~(state==WAIT & md_done). The done cycle releases the stall, so an MFLO in decode reaches EX and reads the updated LO with zero bubble after writeback.
- Issue-timing contract: mult/div/move issue with busy_o=1 cannot occur, because the stall prevents it. It is undefined if violated; assertions must flag it.
- md_op_a, md_op_b, md_is_div and md_unsigned stay stable from START until the return to IDLE, then hold their last value.
- The sticky error flags clear only on reset.
- Minimum issue-to-result latency: issue edge -> START cycle -> WAIT; the earliest done is the first WAIT cycle, so HI/LO update 2 edges after the issue edge.

Test Plan:
- MULT src_a=0xFFFFFFFD (-3), src_b=5; bench unit answers md_done 4 cycles after md_start with hi=0xFFFFFFFF, lo=0xFFFFFFF1. Required: one md_start pulse; md_is_div=0; hi_o/lo_o updated on the done edge; stall_o high while MFLO sits in decode and low in the done cycle.
- DIVU 100/7, unit latency 32 -> lo_o=14, hi_o=2; busy_o high for 33 cycles; md_unsigned=1 held throughout.
- DIV src_b=0 with hi_o=0x11, lo_o=0x22 -> no md_start; div0_err=1; HI/LO unchanged; busy_o stays 0.
- MTHI wd=0xDEADBEEF, then MTLO wd=0x12345678, both while idle -> hi_o/lo_o updated one edge each. The same MTHI with flush_e=1 -> no change.
- Unit never returns md_done -> after MAX_CYCLES=64 WAIT cycles: IDLE, timeout_err=1, stall_o released. Also assert rst_n low mid-WAIT -> all outputs 0 immediately; no further md_start.
- Back-to-back MULT then DIV in decode -> DIV stalled until the done cycle, then issues; second md_start 2 cycles after the first done edge; both results land correctly.
